// File: rtl/cpu_bus_interface_pkg.sv
// Shared types for the 6502 memory-side bus endpoint.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} bus_state_t;
  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;
endpackage

// File: rtl/cpu_bus_interface_if.sv
// Memory port between the CPU bus endpoint (master) and the system bus (slave).
interface cpu_bus_interface_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_open;

  modport master (output mem_addr, mem_wdata, mem_we, mem_req,
                  input  mem_ack, mem_rdata, mem_open);
  modport slave  (input  mem_addr, mem_wdata, mem_we, mem_req,
                  output mem_ack, mem_rdata, mem_open);
endinterface

// File: rtl/cpu_bus_interface.sv
// 6502 DB endpoint: ABL/ABH/DOR/DL registers plus a one-access-per-cycle req/ack FSM.
// Optional macro CPU_OPEN_BUS_EN: open-bus/timeout reads return the last bus value.
module cpu_bus_interface
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_start,
  input  logic        rw,
  input  logic        ADL_ABL,
  input  logic [7:0]  ADL,
  input  logic        ADH_ABH,
  input  logic [7:0]  ADH,
  input  logic        DB_DOR,
  input  logic [7:0]  DB,
  output logic [7:0]  Input_Data_Latch_Out,
  output logic        ready,
  output logic        overrun,
  cpu_bus_interface_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  bus_state_t       r_state;
  logic [7:0]       r_abl, r_abh, r_dor, r_dl;
  logic             r_rw, r_req, r_we, r_ready, r_overrun;
  logic [CNT_W-1:0] r_cnt;

  logic       w_launch, w_tmo, w_done;
  logic [7:0] w_rd_val;

  assign w_launch = cycle_start && (r_state != REQ);
  assign w_tmo    = (r_state == REQ) && !bus.mem_ack && (r_cnt == CNT_LAST);
  assign w_done   = (r_state == REQ) && (bus.mem_ack || w_tmo);

`ifdef CPU_OPEN_BUS_EN
  logic [7:0] r_last;

  assign w_rd_val = (w_tmo || bus.mem_open) ? r_last : bus.mem_rdata;

  // Last value seen on the external bus: real read data or what we drove.
  always_ff @(posedge clk) begin
    if (reset)
      r_last <= 8'h00;
    else if (w_done && !w_tmo && r_rw && !bus.mem_open)
      r_last <= bus.mem_rdata;
    else if (w_done && !r_rw)
      r_last <= r_dor;
  end
`else
  logic w_unused_open;
  assign w_unused_open = bus.mem_open;
  assign w_rd_val      = w_tmo ? OPEN_BUS_DEFAULT : bus.mem_rdata;
`endif

  // Address/data registers load whenever enabled, regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abl <= 8'h00;
      r_abh <= 8'h00;
      r_dor <= 8'h00;
    end else begin
      if (ADL_ABL) r_abl <= ADL;
      if (ADH_ABH) r_abh <= ADH;
      if (DB_DOR)  r_dor <= DB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rw      <= 1'b1;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_ready   <= 1'b1;
      r_overrun <= 1'b0;
      r_cnt     <= '0;
      r_dl      <= 8'h00;
    end else if (w_launch) begin
      r_state <= REQ;
      r_rw    <= rw;
      r_we    <= ~rw;
      r_req   <= 1'b1;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (cycle_start) r_overrun <= 1'b1;
          if (w_done) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
            if (r_rw) r_dl <= w_rd_val;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr          = {r_abh, r_abl};
  assign bus.mem_wdata         = r_dor;
  assign bus.mem_we            = r_we;
  assign bus.mem_req           = r_req;
  assign Input_Data_Latch_Out  = r_dl;
  assign ready                 = r_ready;
  assign overrun               = r_overrun;

endmodule

// File: tb/tb_cpu_bus_interface.sv
// Scoreboard bench for cpu_bus_interface; expectations follow CPU_OPEN_BUS_EN if defined.
module tb_cpu_bus_interface;
  localparam int WAIT_MAX = 16;
`ifdef CPU_OPEN_BUS_EN
  localparam bit OPEN_ON = 1'b1;
`else
  localparam bit OPEN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, cycle_start, rw, ADL_ABL, ADH_ABH, DB_DOR;
  logic [7:0] ADL, ADH, DB, dl;
  logic       ready, overrun;

  cpu_bus_interface_if bus();

  cpu_bus_interface #(.WAIT_MAX(WAIT_MAX), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .cycle_start(cycle_start), .rw(rw),
    .ADL_ABL(ADL_ABL), .ADL(ADL), .ADH_ABH(ADH_ABH), .ADH(ADH),
    .DB_DOR(DB_DOR), .DB(DB), .Input_Data_Latch_Out(dl),
    .ready(ready), .overrun(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] m_dl = 8'h00, m_last = 8'h00;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; a DONE-state caller gives a back-to-back cycle.
  task automatic bus_cycle(input logic r, input logic [15:0] a, input logic [7:0] d,
                           input int ack_after, input logic [7:0] rd, input logic op,
                           input int poke_at);
    logic [7:0] exp;
    int n;
    if (r) begin
      if (ack_after == 0)   exp = OPEN_ON ? m_last : 8'hFF;
      else if (op && OPEN_ON) exp = m_last;
      else                  exp = rd;
      if (ack_after > 0 && !op) m_last = rd;
    end else begin
      exp    = m_dl;
      m_last = d;
    end
    m_dl = exp;
    sb.push_back(exp);

    ADL = a[7:0]; ADH = a[15:8]; DB = d; rw = r;
    ADL_ABL = 1'b1; ADH_ABH = 1'b1; DB_DOR = 1'b1; cycle_start = 1'b1;
    @(negedge clk);
    ADL_ABL = 1'b0; ADH_ABH = 1'b0; DB_DOR = 1'b0; cycle_start = 1'b0;
    ADL = 8'hEE; ADH = 8'hEE; DB = 8'hEE;
    chk("launch_req", bus.mem_req, 1);
    chk("launch_rdy", ready, 0);

    n = 1;
    while (bus.mem_req && n < 40) begin
      chk("addr_hold", bus.mem_addr, a);
      chk("we_hold", bus.mem_we, !r);
      if (!r) chk("wdata_hold", bus.mem_wdata, d);
      if (n == ack_after) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd; bus.mem_open = op;
      end
      if (n == poke_at) cycle_start = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0; bus.mem_open = 1'b0; bus.mem_rdata = 8'h00; cycle_start = 1'b0;
      if (bus.mem_req) n++;
    end
    chk("req_cycles", n, (ack_after > 0) ? ack_after : WAIT_MAX);
    chk("done_rdy", ready, 1);
    chk("done_we", bus.mem_we, 0);
    chk("dl", dl, sb.pop_front());
  endtask

  initial begin
    reset = 1'b1; cycle_start = 1'b0; rw = 1'b1;
    ADL_ABL = 1'b0; ADH_ABH = 1'b0; DB_DOR = 1'b0;
    ADL = 8'h00; ADH = 8'h00; DB = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.mem_open = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rdy", ready, 1);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_dl", dl, 8'h00);
    chk("rst_ovr", overrun, 0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 8'h00);

    @(negedge clk); bus_cycle(1'b1, 16'h1234, 8'h00, 3, 8'hA5, 1'b0, 0);  // read, slow ack
    @(negedge clk); bus_cycle(1'b0, 16'h2000, 8'h5C, 1, 8'h00, 1'b0, 0);  // write, immediate ack
    @(negedge clk); bus_cycle(1'b1, 16'h3000, 8'h00, 0, 8'h00, 1'b0, 0);  // timeout read
    @(negedge clk); bus_cycle(1'b1, 16'h4001, 8'h00, 2, 8'h77, 1'b0, 0);
    @(negedge clk); bus_cycle(1'b1, 16'h4002, 8'h00, 1, 8'h00, 1'b1, 0);  // open bus

    chk("ovr_before", overrun, 0);
    @(negedge clk); bus_cycle(1'b1, 16'h5000, 8'h00, 4, 8'h11, 1'b0, 2);  // start during REQ
    chk("ovr_set", overrun, 1);
    @(negedge clk);
    chk("ovr_no_launch", bus.mem_req, 0);

    @(negedge clk); bus_cycle(1'b1, 16'h6000, 8'h00, 1, 8'h22, 1'b0, 0);
    bus_cycle(1'b0, 16'h6001, 8'h99, 2, 8'h00, 1'b0, 0);                  // back-to-back
    bus_cycle(1'b1, 16'h6002, 8'h00, 1, 8'h33, 1'b0, 0);
    chk("ovr_sticky", overrun, 1);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_cycle(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                int'($urandom_range(1, 5)), 8'($urandom), 1'b0, 0);
    end

    // Reset in the middle of a pending read; a late ack must be ignored.
    @(negedge clk);
    ADL = 8'h44; ADH = 8'h44; ADL_ABL = 1'b1; ADH_ABH = 1'b1; rw = 1'b1; cycle_start = 1'b1;
    @(negedge clk);
    ADL_ABL = 1'b0; ADH_ABH = 1'b0; cycle_start = 1'b0;
    chk("mid_req", bus.mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_dl = 8'h00; m_last = 8'h00;
    sb.push_back(8'h00);
    chk("mrst_req", bus.mem_req, 0);
    chk("mrst_rdy", ready, 1);
    chk("mrst_dl", dl, sb.pop_front());
    chk("mrst_ovr", overrun, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_ack_dl", dl, 8'h00);
    chk("late_ack_req", bus.mem_req, 0);

    @(negedge clk); bus_cycle(1'b1, 16'h7000, 8'h00, 2, 8'h3C, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
